sdram_rd_ctrl_p: RTL and testbench

Parametrised successor to the single-bank SDRAM read engine. It reads a programmable number of bursts from any start bank/row/column and crosses row and bank boundaries on its own. It yields to refresh through the arbiter handshake (rd_req/rd_en/flag_rd_end) and resumes afterwards. Read data is returned through a CAS-latency-aligned capture pipeline with a valid strobe.

---
 rtl/sdram_rd_ctrl_p.sv | 245 ++++++++++++++++++++++++
 tb/tb_sdram_rd_ctrl_p.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_rd_ctrl_p.sv
// Multi-burst SDRAM read engine: crosses row/bank boundaries on its own, yields to refresh
// through the arbiter handshake and returns data through a CAS-latency-aligned capture pipe.
module sdram_rd_ctrl_p #(
  parameter int ROW_W   = 12,
  parameter int COL_W   = 9,
  parameter int BANK_W  = 2,
  parameter int DQ_W    = 16,
  parameter int BURST   = 4,
  parameter int CAS_LAT = 3,
  parameter int T_RCD   = 2,
  parameter int T_RP    = 2,
  parameter int LEN_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_trig,
  input  logic [BANK_W-1:0] rd_start_bank,
  input  logic [ROW_W-1:0]  rd_start_row,
  input  logic [COL_W-1:0]  rd_start_col,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic              ref_req,
  input  logic              rd_en,
  output logic              rd_req,
  output logic              flag_rd_end,
  output logic [3:0]        rd_cmd,
  output logic [ROW_W-1:0]  rd_addr,
  output logic [BANK_W-1:0] bank_addr,
  input  logic [DQ_W-1:0]   sdram_dq,
  output logic [DQ_W-1:0]   rd_data,
  output logic              rd_data_vld,
  output logic              rd_busy,
  output logic              rd_done
);

  localparam int BW     = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int WAIT_W = 8;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam logic [COL_W-1:0]  COL_MASK  = ~COL_W'(BURST - 1);
  localparam logic [COL_W-1:0]  COL_STEP  = COL_W'(BURST);
  localparam logic [BW-1:0]     BURST_END = BW'(BURST - 1);
  localparam logic [WAIT_W-1:0] RCD_LAST  = (T_RCD > 1) ? WAIT_W'(T_RCD - 2) : '0;
  localparam logic [WAIT_W-1:0] TAIL_LAST = WAIT_W'(CAS_LAT - 1);
  localparam logic [WAIT_W-1:0] RP_LAST   = WAIT_W'(T_RP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ACT, S_RCD, S_READ, S_TAIL, S_PRE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d, col_nxt;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
  logic                arb_q, arb_d;
  logic                owned_q, owned_d;
  logic                busy_q, busy_d;
  logic [3:0]          rd_cmd_q, rd_cmd_d;
  logic [ROW_W-1:0]    rd_addr_q, rd_addr_d;
  logic [BANK_W-1:0]   bank_addr_q, bank_addr_d;
  logic                flag_end, done;

  logic                rd_win_q;
  logic [CAS_LAT:0]    vld_sr_q;
  logic [DQ_W-1:0]     rd_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      rem_q       <= '0;
      bcnt_q      <= '0;
      wcnt_q      <= '0;
      arb_q       <= 1'b0;
      owned_q     <= 1'b0;
      busy_q      <= 1'b0;
      rd_cmd_q    <= CMD_NOP;
      rd_addr_q   <= '0;
      bank_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rem_q       <= rem_d;
      bcnt_q      <= bcnt_d;
      wcnt_q      <= wcnt_d;
      arb_q       <= arb_d;
      owned_q     <= owned_d;
      busy_q      <= busy_d;
      rd_cmd_q    <= rd_cmd_d;
      rd_addr_q   <= rd_addr_d;
      bank_addr_q <= bank_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    row_d       = row_q;
    col_d       = col_q;
    col_nxt     = col_q + COL_STEP;
    rem_d       = rem_q;
    bcnt_d      = bcnt_q;
    wcnt_d      = wcnt_q;
    arb_d       = arb_q;
    owned_d     = owned_q;
    busy_d      = busy_q;
    rd_cmd_d    = CMD_NOP;
    rd_addr_d   = '0;
    bank_addr_d = bank_q;
    flag_end    = 1'b0;
    done        = 1'b0;

    if (ref_req && (state_q inside {S_ACT, S_RCD, S_READ, S_TAIL, S_PRE}))
      arb_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (rd_trig) begin
          bank_d  = rd_start_bank;
          row_d   = rd_start_row;
          col_d   = rd_start_col & COL_MASK;
          rem_d   = rd_len;
          owned_d = 1'b0;
          arb_d   = 1'b0;
          if (rd_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
            busy_d  = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (rd_en) begin
          owned_d = 1'b1;
          state_d = S_ACT;
        end
      end
      S_ACT: begin
        rd_cmd_d  = CMD_ACT;
        rd_addr_d = row_q;
        wcnt_d    = '0;
        bcnt_d    = '0;
        state_d   = (T_RCD > 1) ? S_RCD : S_READ;
      end
      S_RCD: begin
        wcnt_d = wcnt_q + WAIT_W'(1);
        if (wcnt_q == RCD_LAST) state_d = S_READ;
      end
      S_READ: begin
        bcnt_d = bcnt_q + BW'(1);
        if (bcnt_q == '0) begin
          rd_cmd_d  = CMD_RD;
          rd_addr_d = ROW_W'(col_q);
          col_d     = col_nxt;
          rem_d     = rem_q - LEN_W'(1);
          // Row is advanced as soon as its last burst issues, so a refresh
          // detour still resumes on the correct row.
          if (col_nxt == '0) begin
            row_d = row_q + ROW_W'(1);
            if (&row_q) bank_d = bank_q + BANK_W'(1);
          end
        end
        if (bcnt_q == BURST_END) begin
          bcnt_d = '0;
          if (rem_q == '0 || col_q == '0 || arb_q) begin
            wcnt_d  = '0;
            state_d = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        wcnt_d = wcnt_q + WAIT_W'(1);
        if (wcnt_q == TAIL_LAST) begin
          wcnt_d  = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (wcnt_q == '0) begin
          rd_cmd_d  = CMD_PRE;
          rd_addr_d = ROW_W'(1) << 10;
        end
        wcnt_d = wcnt_q + WAIT_W'(1);
        if (wcnt_q == RP_LAST) begin
          wcnt_d = '0;
          if (rem_q == '0) begin
            arb_d   = 1'b0;
            state_d = S_DONE;
          end else if (arb_q) begin
            flag_end = 1'b1;
            arb_d    = 1'b0;
            owned_d  = 1'b0;
            state_d  = S_REQ;
          end else begin
            state_d = S_ACT;
          end
        end
      end
      S_DONE: begin
        done     = 1'b1;
        flag_end = owned_q;
        owned_d  = 1'b0;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture pipe: the RD window in command timing is delayed CAS_LAT+1 clks to
  // line up with the registered copy of the data bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_win_q  <= 1'b0;
      vld_sr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      rd_win_q  <= (state_q == S_READ);
      vld_sr_q  <= {vld_sr_q[CAS_LAT-1:0], rd_win_q};
      rd_data_q <= sdram_dq;
    end
  end

  assign rd_req      = (state_q == S_REQ);
  assign flag_rd_end = flag_end;
  assign rd_cmd      = rd_cmd_q;
  assign rd_addr     = rd_addr_q;
  assign bank_addr   = bank_addr_q;
  assign rd_data     = rd_data_q;
  assign rd_data_vld = vld_sr_q[CAS_LAT];
  assign rd_busy     = busy_q;
  assign rd_done     = done;

endmodule

// File: tb/tb_sdram_rd_ctrl_p.sv
// Bench for sdram_rd_ctrl_p: table of read jobs with a scoreboard of expected RD
// addresses and data words, an SDRAM data model, an arbiter model and reset sequences.
module tb_sdram_rd_ctrl_p;

  localparam int ROW_W = 12, COL_W = 9, BANK_W = 2, DQ_W = 16, BURST = 4;
  localparam int CAS_LAT = 3, T_RCD = 2, T_RP = 2, LEN_W = 16;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_trig = 1'b0;
  logic [BANK_W-1:0] rd_start_bank = '0;
  logic [ROW_W-1:0]  rd_start_row = '0;
  logic [COL_W-1:0]  rd_start_col = '0;
  logic [LEN_W-1:0]  rd_len = '0;
  logic              ref_req = 1'b0;
  logic              rd_en = 1'b1;
  logic              rd_req, flag_rd_end, rd_data_vld, rd_busy, rd_done;
  logic [3:0]        rd_cmd;
  logic [ROW_W-1:0]  rd_addr;
  logic [BANK_W-1:0] bank_addr;
  logic [DQ_W-1:0]   sdram_dq = '0;
  logic [DQ_W-1:0]   rd_data;

  sdram_rd_ctrl_p #(
    .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W), .DQ_W(DQ_W), .BURST(BURST),
    .CAS_LAT(CAS_LAT), .T_RCD(T_RCD), .T_RP(T_RP), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .rd_trig(rd_trig), .rd_start_bank(rd_start_bank),
    .rd_start_row(rd_start_row), .rd_start_col(rd_start_col), .rd_len(rd_len),
    .ref_req(ref_req), .rd_en(rd_en), .rd_req(rd_req), .flag_rd_end(flag_rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .bank_addr(bank_addr), .sdram_dq(sdram_dq),
    .rd_data(rd_data), .rd_data_vld(rd_data_vld), .rd_busy(rd_busy), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  bank;
    logic [11:0] row;
    logic [8:0]  col;
    logic [15:0] len;
    int          ref_after;
    int          exp_words, exp_act, exp_pre, exp_req, exp_flag;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [22:0] exp_rd[$];
  logic [15:0] exp_words[$];
  logic [15:0] sched[64];

  int cyc = 0, act_cnt = 0, rd_cnt = 0, pre_cnt = 0, req_cnt = 0, flag_cnt = 0;
  int done_cnt = 0, vld_cnt = 0;
  int ref_base = 0, ref_after = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] word(input logic [1:0] b, input logic [11:0] r,
                                       input logic [8:0] c);
    return {r[6:0], c} ^ {b, r[11:7], 9'd0};
  endfunction

  // SDRAM + arbiter model and output monitor, all sampled on the falling edge
  initial begin : monitor
    logic [11:0] open_row;
    logic [22:0] e;
    logic        first_rd, pre_seen, req_prev;
    int          last_act, last_rd, last_pre, enoff, idx;
    open_row = '0; first_rd = 1'b0; pre_seen = 1'b0; req_prev = 1'b0;
    last_act = 0; last_rd = 0; last_pre = 0; enoff = 0;
    for (int i = 0; i < 64; i++) sched[i] = 16'hBAD0;
    forever begin
      @(negedge clk);
      cyc++;
      ref_req = 1'b0;
      if (rd_data_vld) begin
        vld_cnt++;
        if (exp_words.size() == 0) chk("vld_unexpected", 1, 0);
        else chk("rd_data", rd_data, exp_words.pop_front());
      end
      case (rd_cmd)
        CMD_ACT: begin
          act_cnt++;
          if (pre_seen) chk("trp_gap_ok", (cyc - last_pre) >= T_RP, 1);
          open_row = rd_addr;
          last_act = cyc;
          first_rd = 1'b1;
          pre_seen = 1'b0;
        end
        CMD_RD: begin
          rd_cnt++;
          if (first_rd) chk("trcd_gap", cyc - last_act, T_RCD);
          else chk("rd_spacing", cyc - last_rd, BURST);
          first_rd = 1'b0;
          last_rd  = cyc;
          if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
          else begin
            e = exp_rd.pop_front();
            chk("rd_bank_row_col", {bank_addr, open_row, rd_addr},
                {e[22:21], e[20:9], 3'b000, e[8:0]});
          end
          for (int i = 0; i < BURST; i++)
            sched[(cyc + CAS_LAT + i) % 64] = word(bank_addr, open_row, rd_addr[8:0] + 9'(i));
          if (ref_after != 0 && (rd_cnt - ref_base) == ref_after) ref_req = 1'b1;
        end
        CMD_PRE: begin
          pre_cnt++;
          chk("pre_addr", rd_addr, 12'h400);
          last_pre = cyc;
          pre_seen = 1'b1;
        end
        CMD_NOP: ;
        default: chk("illegal_cmd", rd_cmd, CMD_NOP);
      endcase
      idx = cyc % 64;
      sdram_dq = sched[idx];
      sched[idx] = 16'hBAD0;
      if (rd_req && !req_prev) req_cnt++;
      req_prev = rd_req;
      if (flag_rd_end) begin
        flag_cnt++;
        enoff = 4;
      end else if (enoff > 0) begin
        enoff--;
      end
      rd_en = (enoff == 0);
      if (rd_done) done_cnt++;
    end
  end

  task automatic run_vec(input vec_t v, input int id);
    logic [1:0]  b;
    logic [11:0] r;
    logic [8:0]  c;
    int a0, p0, q0, f0, d0, w0;
    a0 = act_cnt; p0 = pre_cnt; q0 = req_cnt; f0 = flag_cnt; d0 = done_cnt; w0 = vld_cnt;
    b = v.bank; r = v.row; c = v.col & ~9'(BURST - 1);
    for (int k = 0; k < int'(v.len); k++) begin
      exp_rd.push_back({b, r, c});
      for (int i = 0; i < BURST; i++) exp_words.push_back(word(b, r, c + 9'(i)));
      c = c + 9'(BURST);
      if (c == 9'd0) begin
        r = r + 12'd1;
        if (r == 12'd0) b = b + 2'd1;
      end
    end
    @(posedge clk); #1;
    rd_start_bank = v.bank; rd_start_row = v.row; rd_start_col = v.col; rd_len = v.len;
    ref_base = rd_cnt; ref_after = v.ref_after;
    rd_trig = 1'b1;
    @(posedge clk); #1;
    rd_trig = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_busy", id), rd_busy, (v.len != 0));
    chk($sformatf("v%0d_done_early", id), rd_done, (v.len == 0));
    for (int k = 0; k < 3000 && done_cnt == d0; k++) @(negedge clk);
    chk($sformatf("v%0d_done_seen", id), done_cnt - d0, 1);
    repeat (12) @(negedge clk);
    ref_after = 0;
    chk($sformatf("v%0d_words", id), vld_cnt - w0, v.exp_words);
    chk($sformatf("v%0d_act", id), act_cnt - a0, v.exp_act);
    chk($sformatf("v%0d_pre", id), pre_cnt - p0, v.exp_pre);
    chk($sformatf("v%0d_req", id), req_cnt - q0, v.exp_req);
    chk($sformatf("v%0d_flag", id), flag_cnt - f0, v.exp_flag);
    chk($sformatf("v%0d_rd_left", id), exp_rd.size(), 0);
    chk($sformatf("v%0d_word_left", id), exp_words.size(), 0);
    chk($sformatf("v%0d_busy_end", id), rd_busy, 0);
  endtask

  initial begin : main
    vec_t vecs[9];
    //            bank  row       col     len   ref  wrd act pre req flag
    vecs[0] = '{2'd0, 12'd5,    9'd0,   16'd3, 0,   12, 1,  1,  1,  1};
    vecs[1] = '{2'd0, 12'd5,    9'd504, 16'd3, 0,   12, 2,  2,  1,  1};
    vecs[2] = '{2'd1, 12'd4095, 9'd508, 16'd2, 0,   8,  2,  2,  1,  1};
    vecs[3] = '{2'd0, 12'd10,   9'd0,   16'd5, 2,   20, 2,  2,  2,  2};
    vecs[4] = '{2'd0, 12'd9,    9'd0,   16'd0, 0,   0,  0,  0,  0,  0};
    vecs[5] = '{2'd3, 12'd100,  9'd6,   16'd1, 0,   4,  1,  1,  1,  1};
    vecs[6] = '{2'd2, 12'd7,    9'd0,   16'd1, 1,   4,  1,  1,  1,  1};
    vecs[7] = '{2'd0, 12'd20,   9'd504, 16'd3, 2,   12, 2,  2,  2,  2};
    vecs[8] = '{2'd3, 12'd4095, 9'd508, 16'd2, 0,   8,  2,  2,  1,  1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd", rd_cmd, CMD_NOP);
    chk("rst_addr", rd_addr, 0);
    chk("rst_bank", bank_addr, 0);
    chk("rst_req", rd_req, 0);
    chk("rst_flag", flag_rd_end, 0);
    chk("rst_vld", rd_data_vld, 0);
    chk("rst_busy", rd_busy, 0);
    chk("rst_done", rd_done, 0);
    chk("rst_data", rd_data, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Trigger pulses while busy must be ignored
    begin
      int d0;
      d0 = done_cnt;
      vecs[0].ref_after = 0;
      fork
        run_vec(vecs[0], 9);
        begin
          repeat (6) @(posedge clk);
          #2 rd_trig = 1'b1;
          @(posedge clk); #2 rd_trig = 1'b0;
        end
      join
      chk("busy_trig_ignored_done", done_cnt - d0, 1);
    end

    // Reset in the middle of a read aborts at once, then a fresh job runs cleanly
    begin
      vec_t vr;
      int k;
      vr = '{2'd0, 12'd30, 9'd0, 16'd5, 0, 0, 0, 0, 0, 0};
      @(posedge clk); #1;
      rd_start_bank = vr.bank; rd_start_row = vr.row; rd_start_col = vr.col; rd_len = vr.len;
      for (int i = 0; i < 5 * BURST; i++) exp_words.push_back(word(2'd0, 12'd30, 9'(i)));
      for (int i = 0; i < 5; i++) exp_rd.push_back({2'd0, 12'd30, 9'(i * BURST)});
      rd_trig = 1'b1;
      @(posedge clk); #1 rd_trig = 1'b0;
      k = 0;
      while (!rd_data_vld && k < 100) begin
        @(negedge clk);
        k++;
      end
      chk("mid_vld_reached", rd_data_vld, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_cmd", rd_cmd, CMD_NOP);
      chk("mid_rst_vld", rd_data_vld, 0);
      chk("mid_rst_busy", rd_busy, 0);
      chk("mid_rst_req", rd_req, 0);
      exp_words.delete();
      exp_rd.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_vec(vecs[0], 10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
